// File: rtl/saladin_pkg.sv
// Shared types and width helpers for the PLM scheduling fabric.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   TAG_ID_W        - id field width carried in a grant tag (ids are zero-extended into it)
//   grant_tag_t     - {valid, id} tag reported by the scheduler for each granted read
//   cid_width()     - consumer-index width, never less than one bit
//   plm_input_width() - width of one packed scheduler request word
package saladin_pkg;

   localparam int TAG_ID_W = 8;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } grant_tag_t;

   function automatic int cid_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Request word as the scheduler packs it: address, bank select, write data, write enable.
   function automatic int plm_input_width(input int addr_w, input int nbanks, input int value_w);
      return addr_w + cid_width(nbanks) + value_w + 1;
   endfunction

endpackage

// File: rtl/resp_fifo2.sv
// Two-entry registered response FIFO for one consumer.
// Latency: a push becomes visible at the head on the following cycle (no bypass).
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
//
// Ports:
//   clk, reset          - clock, asynchronous active-low reset
//   push, push_data     - write request and word
//   pop                 - remove the head (ignored while empty)
//   head                - head word, zero after reset
//   full, empty         - occupancy flags
module resp_fifo2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   logic [1:0]       cnt;
   logic [WIDTH-1:0] head_q;
   logic [WIDTH-1:0] tail_q;
   logic             do_pop;
   logic             do_push;

   assign empty   = (cnt == 2'd0);
   assign full    = (cnt == 2'd2);
   assign do_pop  = pop && !empty;
   // A full FIFO can still take a word when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = head_q;

   // The head is always its own register so the consumer sees a flop output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         case (cnt)
            2'd0: begin
               if (do_push) begin
                  head_q <= push_data;
                  cnt    <= 2'd1;
               end
            end
            2'd1: begin
               if (do_pop && do_push) begin
                  head_q <= push_data;
               end else if (do_pop) begin
                  cnt <= 2'd0;
               end else if (do_push) begin
                  tail_q <= push_data;
                  cnt    <= 2'd2;
               end
            end
            default: begin
               if (do_pop) begin
                  head_q <= tail_q;
                  if (do_push) begin
                     tail_q <= push_data;
                  end else begin
                     cnt <= 2'd1;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/plm_response_router.sv
// Return path of the PLM fabric: delays grant tags by MEM_LATENCY, pairs them with bank read data, routes to per-consumer FIFOs.
// Latency: grant in cycle t, bank_rdata in cycle t+MEM_LATENCY, resp_valid in cycle t+MEM_LATENCY+1.
// Backpressure: none upstream; each consumer drains via resp_valid/resp_ack, words arriving at a full FIFO are dropped.
//
// Ports:
//   clk, reset       - clock, asynchronous active-low reset
//   grant_valid/id   - per-kernel grant tag from the request scheduler
//   bank_rdata       - per-kernel read data, aligned with the tag MEM_LATENCY cycles later
//   resp_valid/data  - per-consumer FIFO head
//   resp_ack         - per-consumer head accept
//   overflow         - per-consumer sticky drop flag, cleared only by reset
//
// Build option RESP_OVERFLOW_EN: when defined, overflow flags FIFO-full and
// same-consumer collision drops; otherwise overflow is tied low and drops are silent.
module plm_response_router
   import saladin_pkg::*;
#(
   parameter  int ADDR_WIDTH  = 4,
   parameter  int VALUE_WIDTH = 8,
   parameter  int NCONSUMERS  = 2,
   parameter  int NBANKS      = 1,
   parameter  int NPORTS      = 1,
   parameter  int MEM_LATENCY = 1,
   localparam int NKERNELS    = NBANKS * NPORTS,
   localparam int CID_WIDTH   = cid_width(NCONSUMERS)
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NKERNELS-1:0]                    grant_valid,
   input  logic [NKERNELS-1:0][CID_WIDTH-1:0]     grant_id,
   input  logic [NKERNELS-1:0][VALUE_WIDTH-1:0]   bank_rdata,
   output logic [NCONSUMERS-1:0]                  resp_valid,
   output logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] resp_data,
   input  logic [NCONSUMERS-1:0]                  resp_ack,
   output logic [NCONSUMERS-1:0]                  overflow
);

   // Elaboration-time parameter sanity (ADDR_WIDTH is otherwise only carried for the scheduler).
   if (MEM_LATENCY < 1 || MEM_LATENCY > 8) begin : g_bad_latency
      $error("plm_response_router: MEM_LATENCY must be in 1..8");
   end
   if (ADDR_WIDTH < 1) begin : g_bad_addr
      $error("plm_response_router: ADDR_WIDTH must be at least 1");
   end
   if (CID_WIDTH > TAG_ID_W) begin : g_bad_cid
      $error("plm_response_router: consumer id wider than the grant tag id field");
   end

   // ------------------------------------------------------------------
   // Tag delay line: one MEM_LATENCY-deep {valid, id} shift register per kernel.
   // ------------------------------------------------------------------
   grant_tag_t tag_pipe [NKERNELS][MEM_LATENCY];
   grant_tag_t tag_out  [NKERNELS];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NKERNELS; k++) begin
            for (int s = 0; s < MEM_LATENCY; s++) begin
               tag_pipe[k][s] <= '0;
            end
         end
      end else begin
         for (int k = 0; k < NKERNELS; k++) begin
            tag_pipe[k][0] <= '{valid: grant_valid[k], id: TAG_ID_W'(grant_id[k])};
            for (int s = 1; s < MEM_LATENCY; s++) begin
               tag_pipe[k][s] <= tag_pipe[k][s-1];
            end
         end
      end
   end

   for (genvar k = 0; k < NKERNELS; k++) begin : g_tag_out
      assign tag_out[k] = tag_pipe[k][MEM_LATENCY-1];
   end

   // ------------------------------------------------------------------
   // Routing: the lowest-index kernel emerging for a consumer owns that
   // consumer's push this cycle. Ids at or above NCONSUMERS match nothing
   // and therefore vanish without a flag.
   // ------------------------------------------------------------------
   logic [NCONSUMERS-1:0]                  push;
   logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] push_data;

   always_comb begin
      push      = '0;
      push_data = '0;
      for (int c = 0; c < NCONSUMERS; c++) begin
         for (int k = 0; k < NKERNELS; k++) begin
            if (!push[c] && tag_out[k].valid && tag_out[k].id == TAG_ID_W'(c)) begin
               push[c]      = 1'b1;
               push_data[c] = bank_rdata[k];
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Per-consumer FIFOs
   // ------------------------------------------------------------------
   logic [NCONSUMERS-1:0] fifo_full;
   logic [NCONSUMERS-1:0] fifo_empty;
   logic [NCONSUMERS-1:0] pop;

   assign resp_valid = ~fifo_empty;
   assign pop        = resp_ack & ~fifo_empty;

   for (genvar c = 0; c < NCONSUMERS; c++) begin : g_fifo
      resp_fifo2 #(
         .WIDTH (VALUE_WIDTH)
      ) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .push      (push[c]),
         .push_data (push_data[c]),
         .pop       (pop[c]),
         .head      (resp_data[c]),
         .full      (fifo_full[c]),
         .empty     (fifo_empty[c])
      );
   end

   // ------------------------------------------------------------------
   // Overflow flags
   // ------------------------------------------------------------------
`ifdef RESP_OVERFLOW_EN
   // A second emerging tag for a consumer already claimed this cycle is a collision.
   logic [NCONSUMERS-1:0] seen;
   logic [NCONSUMERS-1:0] collide;

   always_comb begin
      seen    = '0;
      collide = '0;
      for (int c = 0; c < NCONSUMERS; c++) begin
         for (int k = 0; k < NKERNELS; k++) begin
            if (tag_out[k].valid && tag_out[k].id == TAG_ID_W'(c)) begin
               if (seen[c]) begin
                  collide[c] = 1'b1;
               end
               seen[c] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= '0;
      end else begin
         overflow <= overflow | collide | (push & fifo_full & ~pop);
      end
   end
`else
   logic full_unused;
   assign full_unused = |fifo_full;
   assign overflow    = '0;
`endif

endmodule

// File: tb/tb_plm_response_router.sv
// Bench for plm_response_router: MEM_LATENCY=3, two kernels, three consumers (id 3 is out of range).
// Stimulus pushes expected words into per-consumer queues; a negedge monitor pops on every handshake.
module tb_plm_response_router;

   localparam int ML = 3;
   localparam int NB = 2;
   localparam int NC = 3;
   localparam int VW = 8;
   localparam int CW = 2;
`ifdef RESP_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NB-1:0]          grant_valid;
   logic [NB-1:0][CW-1:0]  grant_id;
   logic [NB-1:0][VW-1:0]  bank_rdata;
   logic [NC-1:0]          resp_valid;
   logic [NC-1:0][VW-1:0]  resp_data;
   logic [NC-1:0]          resp_ack;
   logic [NC-1:0]          overflow;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [NB-1:0][VW-1:0] ring [8];
   logic [VW-1:0]         exp_q [NC][$];

   always #5 clk = ~clk;

   plm_response_router #(
      .ADDR_WIDTH  (4),
      .VALUE_WIDTH (VW),
      .NCONSUMERS  (NC),
      .NBANKS      (NB),
      .NPORTS      (1),
      .MEM_LATENCY (ML)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .bank_rdata  (bank_rdata),
      .resp_valid  (resp_valid),
      .resp_data   (resp_data),
      .resp_ack    (resp_ack),
      .overflow    (overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Advance one cycle; grants last one cycle, bank data comes from the latency ring.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      grant_valid = '0;
      grant_id    = '0;
      bank_rdata  = ring[cyc % 8];
      ring[cyc % 8] = '0;
   endtask

   task automatic issue(input int k, input int id, input logic [VW-1:0] d);
      grant_valid[k] = 1'b1;
      grant_id[k]    = CW'(id);
      ring[(cyc + ML) % 8][k] = d;
   endtask

   task automatic expect_word(input int c, input logic [VW-1:0] d);
      exp_q[c].push_back(d);
   endtask

   // Scoreboard monitor: every accepted head must be the next expected word.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         for (int c = 0; c < NC; c++) begin
            if (resp_valid[c] && resp_ack[c]) begin
               if (exp_q[c].size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_resp c%0d: got 0x%0h, required no response", c, resp_data[c]);
               end else begin
                  chk($sformatf("resp_data_c%0d", c), 32'(resp_data[c]), 32'(exp_q[c].pop_front()));
               end
            end
         end
      end
   end

   initial begin
      reset       = 1'b0;
      grant_valid = '0;
      grant_id    = '0;
      bank_rdata  = '0;
      resp_ack    = '0;
      for (int i = 0; i < 8; i++) ring[i] = '0;

      repeat (2) tick();
      chk("reset_valid", 32'(resp_valid), 32'h0);
      chk("reset_data",  32'(resp_data),  32'h0);
      chk("reset_ovf",   32'(overflow),   32'h0);
      reset = 1'b1;
      tick();

      // Single read: kernel 0 -> consumer 1.
      issue(0, 1, 8'hA5);
      expect_word(1, 8'hA5);
      repeat (3) tick();
      chk("single_early", 32'(resp_valid[1]), 32'h0);
      tick();
      chk("single_valid1", 32'(resp_valid[1]), 32'h1);
      chk("single_valid0", 32'(resp_valid[0]), 32'h0);
      chk("single_data",   32'(resp_data[1]),  32'hA5);
      resp_ack[1] = 1'b1;
      tick();
      resp_ack[1] = 1'b0;
      chk("single_drained", 32'(resp_valid[1]), 32'h0);

      // Back-to-back stream with ack held high.
      resp_ack[0] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         issue(0, 0, VW'(i + 1));
         expect_word(0, VW'(i + 1));
         tick();
      end
      for (int j = 0; j < 4; j++) begin
         tick();
         chk($sformatf("stream_valid_%0d", j), 32'(resp_valid[0]), (j < 3) ? 32'h1 : 32'h0);
      end
      resp_ack[0] = 1'b0;

      // Full FIFO: third word dropped.
      for (int i = 0; i < 3; i++) begin
         issue(0, 0, VW'(i + 1));
         if (i < 2) expect_word(0, VW'(i + 1));
         tick();
      end
      repeat (4) tick();
      chk("full_valid", 32'(resp_valid[0]), 32'h1);
      chk("full_head",  32'(resp_data[0]),  32'h01);
      chk("full_ovf",   32'(overflow[0]),   32'(OVF_EN));
      resp_ack[0] = 1'b1;
      repeat (2) tick();
      resp_ack[0] = 1'b0;
      chk("full_drained", 32'(resp_valid[0]), 32'h0);
      chk("full_ovf_sticky", 32'(overflow[0]), 32'(OVF_EN));

      // Push while full with a simultaneous pop (kernel 1 -> consumer 2).
      issue(1, 2, 8'h11); expect_word(2, 8'h11); tick();
      issue(1, 2, 8'h22); expect_word(2, 8'h22); tick();
      issue(1, 2, 8'h33); expect_word(2, 8'h33); tick();
      repeat (2) tick();
      chk("popfull_valid", 32'(resp_valid[2]), 32'h1);
      chk("popfull_head",  32'(resp_data[2]),  32'h11);
      resp_ack[2] = 1'b1;
      tick();
      resp_ack[2] = 1'b0;
      chk("popfull_after_valid", 32'(resp_valid[2]), 32'h1);
      chk("popfull_after_head",  32'(resp_data[2]),  32'h22);
      chk("popfull_ovf",         32'(overflow[2]),   32'h0);
      resp_ack[2] = 1'b1;
      repeat (2) tick();
      resp_ack[2] = 1'b0;
      chk("popfull_drained", 32'(resp_valid[2]), 32'h0);

      // Collision on consumer 1, then parallel routing to different consumers.
      issue(0, 1, 8'h10); issue(1, 1, 8'h20); expect_word(1, 8'h10); tick();
      issue(0, 0, 8'h44); issue(1, 2, 8'h55); expect_word(0, 8'h44); expect_word(2, 8'h55); tick();
      repeat (3) tick();
      chk("coll_valid", 32'(resp_valid), 32'h7);
      chk("coll_data1", 32'(resp_data[1]), 32'h10);
      chk("coll_ovf1",  32'(overflow[1]), 32'(OVF_EN));
      chk("coll_ovf2",  32'(overflow[2]), 32'h0);
      resp_ack = '1;
      tick();
      resp_ack = '0;
      chk("coll_drained", 32'(resp_valid), 32'h0);

      // Out-of-range id discarded without a flag.
      issue(1, 3, 8'h77); issue(0, 2, 8'h66); expect_word(2, 8'h66);
      repeat (4) tick();
      chk("oor_valid", 32'(resp_valid), 32'h4);
      chk("oor_data2", 32'(resp_data[2]), 32'h66);
      chk("oor_ovf2",  32'(overflow[2]), 32'h0);
      resp_ack[2] = 1'b1;
      tick();
      resp_ack[2] = 1'b0;

      // Reset one cycle after a grant: the tag is lost.
      issue(0, 1, 8'h99);
      tick();
      reset = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(resp_valid), 32'h0);
      chk("rst_mid_data",  32'(resp_data),  32'h0);
      chk("rst_mid_ovf",   32'(overflow),   32'h0);
      repeat (2) tick();
      reset    = 1'b1;
      resp_ack = '1;
      for (int j = 0; j < 6; j++) begin
         tick();
         chk($sformatf("rst_quiet_%0d", j), 32'(resp_valid), 32'h0);
      end
      resp_ack = '0;

      for (int c = 0; c < NC; c++) begin
         chk($sformatf("leftover_c%0d", c), 32'(exp_q[c].size()), 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
